// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package kb_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } kb_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame deserialiser: synchronisers, falling-edge detect,
// frame FSM with odd-parity check and inter-edge timeout.
module ps2_frame_rx
  import kb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid_c,
  output logic [7:0] byte_data_c,
  output logic       frame_err_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;

  frame_state_t   state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  // Synchronisers reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    par_d        = par_q;
    tmo_d        = tmo_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    byte_data_c  = shift_q;

    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      frame_err_c = 1'b1;
      state_d     = ST_IDLE;
      tmo_d       = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {bit_in, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          // Odd parity: XOR of data and parity bit must be 1.
          if (bit_in && (^shift_q ^ par_q)) byte_valid_c = 1'b1;
          else                              frame_err_c  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: scan-code set 2 prefix decode, held-key table and
// frame error counter on top of the frame deserialiser.
module ps2_kb_rx
  import kb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned MAX_KEYS       = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [8*MAX_KEYS-1:0] keys_held,
  output logic                  keys_ovf,
  output logic                  evt_valid,
  output logic [7:0]            evt_code,
  output logic                  evt_ext,
  output logic                  evt_release,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam int unsigned IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  logic       byte_valid_c;
  logic [7:0] byte_data_c;
  logic       frame_err_c;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk         (ACLK),
    .rst         (ARESET),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_valid_c(byte_valid_c),
    .byte_data_c (byte_data_c),
    .frame_err_c (frame_err_c)
  );

  logic [MAX_KEYS-1:0][7:0] table_q, table_d;
  logic                     ovf_q, ovf_d;
  logic                     ext_q, ext_d;
  logic                     brk_q, brk_d;
  kb_evt_t                  evt_q, evt_d;
  logic                     evt_valid_q, evt_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic [7:0]               err_q, err_d;
  logic                     hit, free;
  logic [IW-1:0]            hit_idx, free_idx;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      table_q     <= '0;
      ovf_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= '0;
    end else begin
      table_q     <= table_d;
      ovf_q       <= ovf_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
      frame_err_q <= frame_err_d;
      err_q       <= err_d;
    end
  end

  // Table lookup: any slot holding the code, and the lowest empty slot.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = int'(MAX_KEYS) - 1; i >= 0; i--) begin
      if (byte_data_c != 8'h00 && table_q[i] == byte_data_c) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (table_q[i] == 8'h00) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    table_d     = table_q;
    ovf_d       = ovf_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    evt_d       = evt_q;
    evt_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_d       = err_q;

    if (frame_err_c) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end else if (byte_valid_c) begin
      if (byte_data_c == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data_c == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        evt_valid_d = 1'b1;
        evt_d       = '{code: byte_data_c, ext: ext_q, rel: brk_q};
        ext_d       = 1'b0;
        brk_d       = 1'b0;
        if (!ext_q && byte_data_c != 8'h00) begin
          if (!brk_q) begin
            if (!hit) begin
              if (free) table_d[free_idx] = byte_data_c;
              else      ovf_d             = 1'b1;
            end
          end else if (hit) begin
            // Remove and compact so occupied slots stay contiguous from slot 0.
            for (int i = 0; i < int'(MAX_KEYS) - 1; i++) begin
              if (i >= int'(hit_idx)) table_d[i] = table_q[i+1];
            end
            table_d[MAX_KEYS-1] = 8'h00;
          end
        end
      end
    end
  end

  assign keys_held   = table_q;
  assign keys_ovf    = ovf_q;
  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_q.code;
  assign evt_ext     = evt_q.ext;
  assign evt_release = evt_q.rel;
  assign frame_err   = frame_err_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: PS/2 device model (odd parity, scaled bit period),
// event scoreboard and per-scenario checks.
module tb_ps2_kb_rx;
  import kb_pkg::*;

  localparam int unsigned TMO   = 400;
  localparam int          HP_NS = 80;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keys_held;
  logic        keys_ovf, evt_valid, evt_ext, evt_release, frame_err;
  logic [7:0]  evt_code, err_count;

  int checks = 0;
  int errors = 0;

  kb_evt_t exp_q[$];
  kb_evt_t obs [0:63];
  int      obs_wr = 0;
  int      rd = 0;
  int      fe_cnt = 0;

  ps2_kb_rx #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TMO),
    .MAX_KEYS      (4)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keys_held  (keys_held),
    .keys_ovf   (keys_ovf),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_release(evt_release),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 ACLK = ~ACLK;

  // Capture every cycle of evt_valid / frame_err; a stretched pulse shows up as an extra entry.
  always @(negedge ACLK) begin
    if (evt_valid) begin
      obs[obs_wr % 64] <= '{code: evt_code, ext: evt_ext, rel: evt_release};
      obs_wr <= obs_wr + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    #(HP_NS) ps2_clk = 1'b0;
    #(HP_NS) ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    @(negedge ACLK);
    #2;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(1'b1);
  endtask

  task automatic get_obs(output kb_evt_t o, output bit ok);
    int n = 0;
    while (obs_wr == rd && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    ok = (obs_wr != rd);
    o  = ok ? obs[rd % 64] : kb_evt_t'('0);
    if (ok) rd++;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    cycles(3);
    ARESET = 1'b0;
    cycles(2);
    rd = obs_wr;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (keys_held !== 32'h0) begin $display("FAIL reset_keys got %h want 0", keys_held); errors++; end
    checks++; if (keys_ovf !== 1'b0) begin $display("FAIL reset_ovf got %b want 0", keys_ovf); errors++; end
    checks++; if ({evt_valid, evt_code, evt_ext, evt_release} !== 11'h0) begin
      $display("FAIL reset_evt got v=%b c=%h e=%b r=%b want 0", evt_valid, evt_code, evt_ext, evt_release); errors++; end
    checks++; if ({frame_err, err_count} !== 9'h0) begin
      $display("FAIL reset_err got fe=%b cnt=%h want 0", frame_err, err_count); errors++; end
  endtask

  task automatic test_single_make();
    kb_evt_t e, o; bit ok;
    exp_q.push_back('{code: 8'h1C, ext: 1'b0, rel: 1'b0});
    send_frame(8'h1C, 1'b0);
    cycles(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL single_evt got ok=%b %h want %h", ok, o, e); errors++; end
    end
    checks++; if (obs_wr != rd) begin $display("FAIL single_extra got %0d extra events want 0", obs_wr - rd); errors++; end
    checks++; if (keys_held !== 32'h0000001C) begin $display("FAIL single_keys got %h want 0000001c", keys_held); errors++; end
  endtask

  task automatic test_break();
    kb_evt_t e, o; bit ok;
    logic [7:0] mk [3] = '{8'h1C, 8'h1D, 8'h1B};
    do_reset();
    foreach (mk[i]) begin
      exp_q.push_back('{code: mk[i], ext: 1'b0, rel: 1'b0});
      send_frame(mk[i], 1'b0);
    end
    cycles(10);
    checks++; if (keys_held !== 32'h001B1D1C) begin $display("FAIL break_keys3 got %h want 001b1d1c", keys_held); errors++; end
    exp_q.push_back('{code: 8'h1D, ext: 1'b0, rel: 1'b1});
    send_frame(PS2_PREFIX_BRK, 1'b0);
    send_frame(8'h1D, 1'b0);
    cycles(10);
    checks++; if (keys_held !== 32'h00001B1C) begin $display("FAIL break_keys got %h want 00001b1c", keys_held); errors++; end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL break_evt got ok=%b %h want %h", ok, o, e); errors++; end
    end
    checks++; if (obs_wr != rd) begin $display("FAIL break_extra got %0d extra events want 0", obs_wr - rd); errors++; end
  endtask

  task automatic test_overflow();
    kb_evt_t e, o; bit ok;
    logic [7:0] mk [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    do_reset();
    foreach (mk[i]) begin
      exp_q.push_back('{code: mk[i], ext: 1'b0, rel: 1'b0});
      send_frame(mk[i], 1'b0);
    end
    cycles(10);
    checks++; if (keys_ovf !== 1'b0) begin $display("FAIL ovf_early got %b want 0", keys_ovf); errors++; end
    exp_q.push_back('{code: 8'h2C, ext: 1'b0, rel: 1'b0});
    send_frame(8'h2C, 1'b0);
    cycles(10);
    checks++; if (keys_held !== 32'h2D241D15) begin $display("FAIL ovf_keys got %h want 2d241d15", keys_held); errors++; end
    checks++; if (keys_ovf !== 1'b1) begin $display("FAIL ovf_flag got %b want 1", keys_ovf); errors++; end
    exp_q.push_back('{code: 8'h15, ext: 1'b0, rel: 1'b0});
    send_frame(8'h15, 1'b0);
    cycles(10);
    checks++; if (keys_held !== 32'h2D241D15) begin $display("FAIL repeat_keys got %h want 2d241d15", keys_held); errors++; end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL ovf_evt got ok=%b %h want %h", ok, o, e); errors++; end
    end
  endtask

  task automatic test_parity();
    int fe0;
    do_reset();
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1);
    cycles(20);
    checks++; if (fe_cnt - fe0 != 1) begin $display("FAIL parity_pulse got %0d cycles want 1", fe_cnt - fe0); errors++; end
    checks++; if (err_count !== 8'd1) begin $display("FAIL parity_cnt got %0d want 1", err_count); errors++; end
    checks++; if (obs_wr != rd) begin $display("FAIL parity_evt got %0d events want 0", obs_wr - rd); errors++; end
    checks++; if (keys_held !== 32'h0) begin $display("FAIL parity_keys got %h want 0", keys_held); errors++; end
  endtask

  task automatic test_timeout();
    int fe0, n;
    kb_evt_t e, o; bit ok;
    fe0 = fe_cnt;
    @(negedge ACLK); #2;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cycles(TMO - 40);
    checks++; if (fe_cnt != fe0) begin $display("FAIL tmo_early got %0d errs want 0", fe_cnt - fe0); errors++; end
    n = 0;
    while (fe_cnt == fe0 && n < 80) begin @(negedge ACLK); n++; end
    checks++; if (fe_cnt - fe0 != 1) begin $display("FAIL tmo_fire got %0d errs want 1", fe_cnt - fe0); errors++; end
    checks++; if (err_count !== 8'd2) begin $display("FAIL tmo_cnt got %0d want 2", err_count); errors++; end
    exp_q.push_back('{code: 8'h1C, ext: 1'b0, rel: 1'b0});
    send_frame(8'h1C, 1'b0);
    cycles(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL tmo_recover got ok=%b %h want %h", ok, o, e); errors++; end
    end
    checks++; if (keys_held !== 32'h0000001C) begin $display("FAIL tmo_keys got %h want 0000001c", keys_held); errors++; end
  endtask

  task automatic test_extended();
    kb_evt_t e, o; bit ok;
    exp_q.push_back('{code: 8'h75, ext: 1'b1, rel: 1'b0});
    send_frame(PS2_PREFIX_EXT, 1'b0);
    send_frame(8'h75, 1'b0);
    exp_q.push_back('{code: 8'h75, ext: 1'b1, rel: 1'b1});
    send_frame(PS2_PREFIX_EXT, 1'b0);
    send_frame(PS2_PREFIX_BRK, 1'b0);
    send_frame(8'h75, 1'b0);
    cycles(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL ext_evt got ok=%b %h want %h", ok, o, e); errors++; end
    end
    checks++; if (obs_wr != rd) begin $display("FAIL ext_extra got %0d extra events want 0", obs_wr - rd); errors++; end
    checks++; if (keys_held !== 32'h0000001C) begin $display("FAIL ext_keys got %h want 0000001c", keys_held); errors++; end
  endtask

  task automatic test_edge_codes();
    kb_evt_t e, o; bit ok;
    exp_q.push_back('{code: 8'h00, ext: 1'b0, rel: 1'b0});
    send_frame(8'h00, 1'b0);
    exp_q.push_back('{code: 8'h5A, ext: 1'b0, rel: 1'b1});
    send_frame(PS2_PREFIX_BRK, 1'b0);
    send_frame(8'h5A, 1'b0);
    cycles(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL edge_evt got ok=%b %h want %h", ok, o, e); errors++; end
    end
    checks++; if (keys_held !== 32'h0000001C) begin $display("FAIL edge_keys got %h want 0000001c", keys_held); errors++; end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    kb_evt_t e, o; bit ok;
    @(negedge ACLK); #2;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    fe0 = fe_cnt;
    @(negedge ACLK);
    ARESET = 1'b1;
    cycles(3);
    checks++; if ({keys_held, keys_ovf, evt_valid, evt_code, evt_ext, evt_release, frame_err, err_count} !== '0) begin
      $display("FAIL midrst_out got keys=%h ovf=%b cnt=%h code=%h want 0", keys_held, keys_ovf, err_count, evt_code); errors++; end
    ARESET = 1'b0;
    rd = obs_wr;
    cycles(TMO + 100);
    checks++; if (fe_cnt != fe0) begin $display("FAIL midrst_err got %0d errs want 0", fe_cnt - fe0); errors++; end
    exp_q.push_back('{code: 8'h1C, ext: 1'b0, rel: 1'b0});
    send_frame(8'h1C, 1'b0);
    cycles(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); get_obs(o, ok); checks++;
      if (!ok || o !== e) begin $display("FAIL midrst_evt got ok=%b %h want %h", ok, o, e); errors++; end
    end
    checks++; if (keys_held !== 32'h0000001C) begin $display("FAIL midrst_keys got %h want 0000001c", keys_held); errors++; end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_overflow();
    test_parity();
    test_timeout();
    test_extended();
    test_edge_codes();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
